boom_mshr_alloc_arb: RTL and testbench
======================================

// Module: boom_mshr_alloc_arb
// PURPOSE
//  Front-end controller for the dcache MSHR array. Steers each incoming miss to an MSHR:
//   - secondary merge into a matching entry, or
//   - primary allocation into a free entry, or
//   - NACK.
//  Round-robin arbitrates MSHR TileLink A-channel acquires onto the single memory port.
//  Routes D-channel grants back to the owning MSHR by source id.
//  Sits between the LSU miss path, BoomMSHR instances and the TL A/D ports.
// PARAMETERS
//  N_MSHRS   4   number of BoomMSHR entries; TL source id == MSHR index
//  IDX_BITS  6   set-index width
//  TAG_BITS  20  line-tag width
//  ACQ_W     64  packed acquire payload width (opcode/param/address/size), passed through
//  SRC_W     2   $clog2(N_MSHRS)
// PORTS
//  clock          in   1              clock
//  reset          in   1              async active-high reset
//  req_valid      in   1              miss request from LSU
//  req_ready      out  1              request accepted (pri or sec) this cycle
//  req_nack       out  1              request refused this cycle (LSU replays)
//  req_idx        in   IDX_BITS       miss set index
//  req_tag        in   TAG_BITS       miss line tag
//  mshr_pri_val   out  N_MSHRS        one-hot primary-allocate strobe
//  mshr_sec_val   out  N_MSHRS        one-hot secondary-merge strobe
//  mshr_pri_rdy   in   N_MSHRS        entry free
//  mshr_sec_rdy   in   N_MSHRS        entry can take a secondary
//  mshr_idx_vld   in   N_MSHRS        entry idx valid
//  mshr_idx       in   N*IDX_BITS     entry idx, entry i at [i*IDX_BITS +: IDX_BITS]
//  mshr_tag_vld   in   N_MSHRS        entry tag valid
//  mshr_tag       in   N*TAG_BITS     entry tag
//  acq_valid      in   N_MSHRS        per-MSHR acquire request
//  acq_ready      out  N_MSHRS        per-MSHR acquire accepted
//  acq_bits       in   N*ACQ_W        per-MSHR acquire payload
//  mem_acq_valid  out  1              TL A valid
//  mem_acq_ready  in   1              TL A ready
//  mem_acq_bits   out  ACQ_W          TL A payload
//  mem_acq_source out  SRC_W          TL A source (winning MSHR index)
//  mem_gnt_valid  in   1              TL D valid
//  mem_gnt_ready  out  1              TL D ready
//  mem_gnt_source in   SRC_W          TL D source
//  mem_gnt_last   in   1              last beat of grant
//  gnt_valid      out  N_MSHRS        grant beat routed to MSHR
//  gnt_ready      in   N_MSHRS        MSHR accepts grant beat
//  busy_count     out  SRC_W+1        popcount of outstanding acquires
//  err_unexp_gnt  out  1              sticky: grant to source with no outstanding acquire
// BEHAVIOUR
//  Reset (async):
//   - alloc_ptr=0, acq_ptr=0, lock=0, outstanding=0, err_unexp_gnt=0.
//   - All strobes/valids low; busy_count=0.
//  Steering (combinational, 0-cycle):
//   - idx_hit[i] = idx_vld[i] & idx==req_idx.
//   - tag_hit[i] = idx_hit[i] & tag_vld[i] & tag==req_tag.
//   - If any tag_hit with sec_rdy: sec_val to lowest such i; req_ready=1.
//   - Else if any idx_hit: req_nack=1 (set conflict or secondary full); no strobe.
//   - Else if any pri_rdy: pri_val to first free at/after alloc_ptr (wrapping); req_ready=1.
//     On that fire, alloc_ptr <= winner+1 mod N.
//   - Else (all busy): req_nack=1.
//   - All strobes, req_ready and req_nack are gated by req_valid.
//   - req_ready and req_nack are mutually exclusive.
//  Acquire arbiter:
//   - eligible = acq_valid & ~outstanding.
//   - If lock=0: winner = first eligible at/after acq_ptr.
//   - If mem_acq_valid & ~mem_acq_ready: lock=1, held winner; payload/source stable until fire.
//     If the locked MSHR drops acq_valid, it still holds the lock (TL protocol forbids dropping).
//   - Fire (valid&ready): acq_ready[winner]=1, outstanding[winner]<=1, acq_ptr<=winner+1, lock<=0.
//   - Fire is 0-cycle through; no payload buffering.
//  Grant routing:
//   - gnt_valid[src] = mem_gnt_valid; mem_gnt_ready = gnt_ready[src].
//   - On fire & last: outstanding[src]<=0.
//   - Fire with outstanding[src]==0: err_unexp_gnt<=1 (sticky until reset); beat is still routed.
//   - Same-source acquire fire and grant clear in one cycle cannot occur, because outstanding
//     masks eligibility.
//   - Different-source set and clear in the same cycle both take effect.
//  busy_count is registered popcount(outstanding), one cycle after the change.
// STRUCTURE
//  Package boom_lsu_st:
//   - MshrAllocReqST {idx, tag}
//   - MshrSteerE {STEER_SEC, STEER_PRI, STEER_NACK}
//   - localparam nMSHRs
//  Sub-module rr_pick #(N): (valid[N], ptr) -> (any, onehot, idx). Instantiated twice
//  (allocation, acquire).
// TESTING
//  1 Reset; entry0 free; req idx=5 tag=0x10 -> pri_val=0001, ready=1; alloc_ptr=1.
//  2 Entry0 idx=5 tag=0x10, sec_rdy=1; req idx=5 tag=0x10 -> sec_val=0001.
//    Same with tag=0x11 -> nack=1, no strobe.
//  3 All pri_rdy=0, no idx hit -> nack=1.
//    Free entries {1,3}, alloc_ptr=2 -> pri_val=1000.
//  4 acq_valid=1111, mem_acq_ready low 3 cycles then high -> source=0 held stable; then 1, 2, 3
//    in order; busy_count reaches 4.
//  5 Grant src=2, 4 beats, last on 4th -> gnt_valid=0100 each beat; outstanding[2] clears;
//    MSHR2 eligible again next cycle.
//  6 Grant src=1 with outstanding[1]=0 -> err_unexp_gnt=1 sticky.
//    Assert reset mid-lock -> all state 0 immediately.

Source files
------------

// File: rtl/boom_mshr_alloc_arb_pkg.sv
// Shared types for the dcache MSHR allocation front end.
// Holds the miss request bundle, steering decision and default sizes.
package boom_lsu_st;

   localparam int nMSHRs      = 4;
   localparam int MSHR_IDX_W  = 6;
   localparam int MSHR_TAG_W  = 20;

   typedef struct packed {
      logic [MSHR_IDX_W-1:0] idx;
      logic [MSHR_TAG_W-1:0] tag;
   } MshrAllocReqST;

   typedef enum logic [1:0] {
      STEER_SEC,
      STEER_PRI,
      STEER_NACK
   } MshrSteerE;

endpackage

// File: rtl/boom_mshr_alloc_arb_rr_pick.sv
// Round-robin picker: first set bit of valid_i at or after ptr_i, wrapping.
// Ports: valid_i (requests), ptr_i (start position) -> any_o, onehot_o, idx_o.
module rr_pick #(
   parameter int N = 4,
   parameter int W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0] valid_i,
   input  logic [W-1:0] ptr_i,
   output logic         any_o,
   output logic [N-1:0] onehot_o,
   output logic [W-1:0] idx_o
);

   logic [W-1:0] j;

   always_comb begin
      any_o    = 1'b0;
      onehot_o = '0;
      idx_o    = '0;
      j        = '0;
      for (int k = 0; k < N; k++) begin
         j = W'((int'(ptr_i) + k) % N);
         if (!any_o && valid_i[j]) begin
            any_o       = 1'b1;
            onehot_o[j] = 1'b1;
            idx_o       = j;
         end
      end
   end

endmodule

// File: rtl/boom_mshr_alloc_arb.sv
// MSHR front end: steers LSU misses (merge / allocate / nack), round-robin
// arbitrates MSHR acquires onto TL-A and routes TL-D grants by source id.
// Ports: clock/reset; req_* LSU miss; mshr_* entry state and strobes;
// acq_* per-MSHR acquires; mem_acq_* TL-A; mem_gnt_* TL-D; gnt_* per-MSHR
// grant beats; busy_count outstanding acquires; err_unexp_gnt sticky error.
module boom_mshr_alloc_arb
   import boom_lsu_st::*;
#(
   parameter int N_MSHRS  = nMSHRs,
   parameter int IDX_BITS = MSHR_IDX_W,
   parameter int TAG_BITS = MSHR_TAG_W,
   parameter int ACQ_W    = 64,
   parameter int SRC_W    = $clog2(N_MSHRS)
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic                        req_valid,
   output logic                        req_ready,
   output logic                        req_nack,
   input  logic [IDX_BITS-1:0]         req_idx,
   input  logic [TAG_BITS-1:0]         req_tag,
   output logic [N_MSHRS-1:0]          mshr_pri_val,
   output logic [N_MSHRS-1:0]          mshr_sec_val,
   input  logic [N_MSHRS-1:0]          mshr_pri_rdy,
   input  logic [N_MSHRS-1:0]          mshr_sec_rdy,
   input  logic [N_MSHRS-1:0]          mshr_idx_vld,
   input  logic [N_MSHRS*IDX_BITS-1:0] mshr_idx,
   input  logic [N_MSHRS-1:0]          mshr_tag_vld,
   input  logic [N_MSHRS*TAG_BITS-1:0] mshr_tag,
   input  logic [N_MSHRS-1:0]          acq_valid,
   output logic [N_MSHRS-1:0]          acq_ready,
   input  logic [N_MSHRS*ACQ_W-1:0]    acq_bits,
   output logic                        mem_acq_valid,
   input  logic                        mem_acq_ready,
   output logic [ACQ_W-1:0]            mem_acq_bits,
   output logic [SRC_W-1:0]            mem_acq_source,
   input  logic                        mem_gnt_valid,
   output logic                        mem_gnt_ready,
   input  logic [SRC_W-1:0]            mem_gnt_source,
   input  logic                        mem_gnt_last,
   output logic [N_MSHRS-1:0]          gnt_valid,
   input  logic [N_MSHRS-1:0]          gnt_ready,
   output logic [SRC_W:0]              busy_count,
   output logic                        err_unexp_gnt
);

   function automatic logic [SRC_W-1:0] ptr_inc(input logic [SRC_W-1:0] p);
      return (int'(p) == N_MSHRS - 1) ? '0 : p + 1'b1;
   endfunction

   function automatic logic [N_MSHRS-1:0] to_oh(input logic [SRC_W-1:0] s);
      to_oh    = '0;
      to_oh[s] = 1'b1;
   endfunction

   function automatic logic [SRC_W:0] popc(input logic [N_MSHRS-1:0] v);
      popc = '0;
      for (int i = 0; i < N_MSHRS; i++)
         popc = popc + {{SRC_W{1'b0}}, v[i]};
   endfunction

   logic [SRC_W-1:0]   alloc_ptr_q, alloc_ptr_d;
   logic [SRC_W-1:0]   acq_ptr_q, acq_ptr_d;
   logic [SRC_W-1:0]   lock_src_q, lock_src_d;
   logic               lock_q, lock_d;
   logic [N_MSHRS-1:0] outst_q, outst_d;
   logic               err_q, err_d;
   logic [SRC_W:0]     busy_q;

   // ---------------- miss steering ----------------
   MshrAllocReqST      req_s;
   MshrSteerE          steer;
   logic [N_MSHRS-1:0] idx_hit, tag_hit, sec_cand, sec_oh;
   logic               pri_any;
   logic [N_MSHRS-1:0] pri_oh;
   logic [SRC_W-1:0]   pri_idx;

   assign req_s = '{idx: req_idx, tag: req_tag};

   always_comb begin
      idx_hit = '0;
      tag_hit = '0;
      for (int i = 0; i < N_MSHRS; i++) begin
         idx_hit[i] = mshr_idx_vld[i] &&
                      (mshr_idx[i*IDX_BITS +: IDX_BITS] == req_s.idx);
         tag_hit[i] = idx_hit[i] && mshr_tag_vld[i] &&
                      (mshr_tag[i*TAG_BITS +: TAG_BITS] == req_s.tag);
      end
   end

   assign sec_cand = tag_hit & mshr_sec_rdy;
   // isolate lowest set bit: x & -x
   assign sec_oh   = sec_cand & (~sec_cand + N_MSHRS'(1));

   rr_pick #(.N(N_MSHRS), .W(SRC_W)) u_alloc_pick (
      .valid_i  (mshr_pri_rdy),
      .ptr_i    (alloc_ptr_q),
      .any_o    (pri_any),
      .onehot_o (pri_oh),
      .idx_o    (pri_idx)
   );

   // an index hit without a mergeable tag is a set conflict: never
   // allocate a second entry for the same set
   always_comb begin
      steer = STEER_NACK;
      if (|sec_cand)
         steer = STEER_SEC;
      else if (|idx_hit)
         steer = STEER_NACK;
      else if (pri_any)
         steer = STEER_PRI;
   end

   assign mshr_sec_val = (req_valid && steer == STEER_SEC) ? sec_oh : '0;
   assign mshr_pri_val = (req_valid && steer == STEER_PRI) ? pri_oh : '0;
   assign req_ready    = req_valid && (steer != STEER_NACK);
   assign req_nack     = req_valid && (steer == STEER_NACK);
   assign alloc_ptr_d  = (req_valid && steer == STEER_PRI) ?
                         ptr_inc(pri_idx) : alloc_ptr_q;

   // ---------------- acquire arbiter ----------------
   logic [N_MSHRS-1:0] eligible, acq_oh, sel_oh;
   logic               acq_any, acq_fire;
   logic [SRC_W-1:0]   acq_idx, sel_src;

   assign eligible = acq_valid & ~outst_q;

   rr_pick #(.N(N_MSHRS), .W(SRC_W)) u_acq_pick (
      .valid_i  (eligible),
      .ptr_i    (acq_ptr_q),
      .any_o    (acq_any),
      .onehot_o (acq_oh),
      .idx_o    (acq_idx)
   );

   // once presented, the winner stays on the bus until accepted
   assign sel_src        = lock_q ? lock_src_q : acq_idx;
   assign sel_oh         = lock_q ? to_oh(lock_src_q) : acq_oh;
   assign mem_acq_valid  = lock_q | acq_any;
   assign mem_acq_source = sel_src;
   assign mem_acq_bits   = acq_bits[int'(sel_src)*ACQ_W +: ACQ_W];
   assign acq_fire       = mem_acq_valid & mem_acq_ready;
   assign acq_ready      = acq_fire ? sel_oh : '0;
   assign lock_d         = mem_acq_valid & ~mem_acq_ready;
   assign lock_src_d     = sel_src;
   assign acq_ptr_d      = acq_fire ? ptr_inc(sel_src) : acq_ptr_q;

   // ---------------- grant routing ----------------
   logic [N_MSHRS-1:0] gnt_oh, set_v, clr_v;
   logic               gnt_fire;

   assign gnt_oh        = to_oh(mem_gnt_source);
   assign gnt_valid     = mem_gnt_valid ? gnt_oh : '0;
   assign mem_gnt_ready = gnt_ready[mem_gnt_source];
   assign gnt_fire      = mem_gnt_valid & mem_gnt_ready;

   assign set_v   = acq_fire ? sel_oh : '0;
   assign clr_v   = (gnt_fire && mem_gnt_last) ? gnt_oh : '0;
   assign outst_d = (outst_q | set_v) & ~clr_v;
   assign err_d   = err_q | (gnt_fire & ~outst_q[mem_gnt_source]);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         alloc_ptr_q <= '0;
         acq_ptr_q   <= '0;
         lock_q      <= 1'b0;
         lock_src_q  <= '0;
         outst_q     <= '0;
         err_q       <= 1'b0;
         busy_q      <= '0;
      end else begin
         alloc_ptr_q <= alloc_ptr_d;
         acq_ptr_q   <= acq_ptr_d;
         lock_q      <= lock_d;
         lock_src_q  <= lock_src_d;
         outst_q     <= outst_d;
         err_q       <= err_d;
         busy_q      <= popc(outst_q);
      end
   end

   assign busy_count    = busy_q;
   assign err_unexp_gnt = err_q;

endmodule

// File: tb/tb_boom_mshr_alloc_arb.sv
// Directed scoreboard bench for boom_mshr_alloc_arb.
// Expectations are queued as stimulus is driven and popped at each check.
module tb_boom_mshr_alloc_arb;

   localparam int N  = 4;
   localparam int IB = 6;
   localparam int TBW = 20;
   localparam int AW = 64;
   localparam int SW = 2;

   logic              clock = 1'b0;
   logic              reset = 1'b1;
   logic              req_valid = 1'b0;
   logic              req_ready, req_nack;
   logic [IB-1:0]     req_idx = '0;
   logic [TBW-1:0]    req_tag = '0;
   logic [N-1:0]      mshr_pri_val, mshr_sec_val;
   logic [N-1:0]      mshr_pri_rdy = '0;
   logic [N-1:0]      mshr_sec_rdy = '0;
   logic [N-1:0]      mshr_idx_vld = '0;
   logic [N*IB-1:0]   mshr_idx = '0;
   logic [N-1:0]      mshr_tag_vld = '0;
   logic [N*TBW-1:0]  mshr_tag = '0;
   logic [N-1:0]      acq_valid = '0;
   logic [N-1:0]      acq_ready;
   logic [N*AW-1:0]   acq_bits = '0;
   logic              mem_acq_valid;
   logic              mem_acq_ready = 1'b0;
   logic [AW-1:0]     mem_acq_bits;
   logic [SW-1:0]     mem_acq_source;
   logic              mem_gnt_valid = 1'b0;
   logic              mem_gnt_ready;
   logic [SW-1:0]     mem_gnt_source = '0;
   logic              mem_gnt_last = 1'b0;
   logic [N-1:0]      gnt_valid;
   logic [N-1:0]      gnt_ready = '0;
   logic [SW:0]       busy_count;
   logic              err_unexp_gnt;

   int tests = 0;
   int fails = 0;

   typedef struct {
      string       tag;
      logic [63:0] val;
   } exp_t;

   exp_t sb[$];

   always #5 clock = ~clock;

   boom_mshr_alloc_arb dut (
      .clock          (clock),
      .reset          (reset),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_nack       (req_nack),
      .req_idx        (req_idx),
      .req_tag        (req_tag),
      .mshr_pri_val   (mshr_pri_val),
      .mshr_sec_val   (mshr_sec_val),
      .mshr_pri_rdy   (mshr_pri_rdy),
      .mshr_sec_rdy   (mshr_sec_rdy),
      .mshr_idx_vld   (mshr_idx_vld),
      .mshr_idx       (mshr_idx),
      .mshr_tag_vld   (mshr_tag_vld),
      .mshr_tag       (mshr_tag),
      .acq_valid      (acq_valid),
      .acq_ready      (acq_ready),
      .acq_bits       (acq_bits),
      .mem_acq_valid  (mem_acq_valid),
      .mem_acq_ready  (mem_acq_ready),
      .mem_acq_bits   (mem_acq_bits),
      .mem_acq_source (mem_acq_source),
      .mem_gnt_valid  (mem_gnt_valid),
      .mem_gnt_ready  (mem_gnt_ready),
      .mem_gnt_source (mem_gnt_source),
      .mem_gnt_last   (mem_gnt_last),
      .gnt_valid      (gnt_valid),
      .gnt_ready      (gnt_ready),
      .busy_count     (busy_count),
      .err_unexp_gnt  (err_unexp_gnt)
   );

   task automatic push(input string t, input logic [63:0] v);
      exp_t e;
      e.tag = t;
      e.val = v;
      sb.push_back(e);
   endtask

   task automatic pop_chk(input logic [63:0] obs);
      exp_t e;
      tests++;
      if (sb.size() == 0) begin
         fails++;
         $display("FAIL sb_empty observed=%0h required=<none>", obs);
      end else begin
         e = sb.pop_front();
         assert (obs === e.val)
         else begin
            fails++;
            $error("FAIL %s observed=%0h required=%0h", e.tag, obs, e.val);
         end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < N; i++)
         acq_bits[i*AW +: AW] = 64'hA000_0000_0000_0000 | 64'(i);

      // reset state
      #2;
      push("rst_pri", 0);
      push("rst_acqv", 0);
      push("rst_busy", 0);
      push("rst_err", 0);
      pop_chk(mshr_pri_val);
      pop_chk(mem_acq_valid);
      pop_chk(busy_count);
      pop_chk(err_unexp_gnt);

      // primary allocation into entry 0
      @(negedge clock);
      reset = 1'b0;
      req_valid = 1'b1;
      req_idx = 6'd5;
      req_tag = 20'h10;
      mshr_pri_rdy = 4'b0001;
      push("t1_pri", 4'b0001);
      push("t1_ready", 1);
      push("t1_nack", 0);
      #1;
      pop_chk(mshr_pri_val);
      pop_chk(req_ready);
      pop_chk(req_nack);

      // alloc_ptr advanced to 1
      @(negedge clock);
      mshr_pri_rdy = 4'b1111;
      push("t1_ptr1", 4'b0010);
      #1;
      pop_chk(mshr_pri_val);

      // secondary merge into entry 0
      @(negedge clock);
      mshr_idx_vld = 4'b0001;
      mshr_idx[0 +: IB] = 6'd5;
      mshr_tag_vld = 4'b0001;
      mshr_tag[0 +: TBW] = 20'h10;
      mshr_sec_rdy = 4'b0001;
      mshr_pri_rdy = 4'b1110;
      push("t2_sec", 4'b0001);
      push("t2_pri", 0);
      push("t2_ready", 1);
      #1;
      pop_chk(mshr_sec_val);
      pop_chk(mshr_pri_val);
      pop_chk(req_ready);

      // set conflict: idx hit, tag miss
      @(negedge clock);
      req_tag = 20'h11;
      push("t2_conf_nack", 1);
      push("t2_conf_ready", 0);
      push("t2_conf_sec", 0);
      push("t2_conf_pri", 0);
      #1;
      pop_chk(req_nack);
      pop_chk(req_ready);
      pop_chk(mshr_sec_val);
      pop_chk(mshr_pri_val);

      // tag hit but secondary full
      @(negedge clock);
      req_tag = 20'h10;
      mshr_sec_rdy = 4'b0000;
      push("t2_full_nack", 1);
      push("t2_full_sec", 0);
      #1;
      pop_chk(req_nack);
      pop_chk(mshr_sec_val);

      // all entries busy
      @(negedge clock);
      mshr_idx_vld = '0;
      mshr_tag_vld = '0;
      mshr_pri_rdy = 4'b0000;
      req_idx = 6'd9;
      push("t3_busy_nack", 1);
      push("t3_busy_pri", 0);
      #1;
      pop_chk(req_nack);
      pop_chk(mshr_pri_val);

      // free {1,3} with alloc_ptr=2
      @(negedge clock);
      mshr_pri_rdy = 4'b1010;
      push("t3_rr_pri", 4'b1000);
      push("t3_rr_ready", 1);
      #1;
      pop_chk(mshr_pri_val);
      pop_chk(req_ready);

      // pointer wrapped to 0
      @(negedge clock);
      push("t3_wrap_pri", 4'b0010);
      #1;
      pop_chk(mshr_pri_val);
      req_valid = 1'b0;
      mshr_pri_rdy = 4'b1111;
      push("t3_gate_pri", 0);
      push("t3_gate_ready", 0);
      push("t3_gate_nack", 0);
      #1;
      pop_chk(mshr_pri_val);
      pop_chk(req_ready);
      pop_chk(req_nack);

      // acquire arbitration with back-pressure
      @(negedge clock);
      mshr_pri_rdy = '0;
      acq_valid = 4'b1111;
      push("t4_v", 1);
      push("t4_src", 0);
      push("t4_bits", 64'hA000_0000_0000_0000);
      push("t4_ardy", 0);
      #1;
      pop_chk(mem_acq_valid);
      pop_chk(mem_acq_source);
      pop_chk(mem_acq_bits);
      pop_chk(acq_ready);

      @(negedge clock);
      acq_valid = 4'b1110;
      push("t4_drop_v", 1);
      push("t4_drop_src", 0);
      push("t4_drop_ardy", 0);
      #1;
      pop_chk(mem_acq_valid);
      pop_chk(mem_acq_source);
      pop_chk(acq_ready);

      @(negedge clock);
      acq_valid = 4'b1111;
      push("t4_hold_src", 0);
      #1;
      pop_chk(mem_acq_source);

      @(negedge clock);
      mem_acq_ready = 1'b1;
      push("t4_f0_ardy", 4'b0001);
      push("t4_f0_src", 0);
      #1;
      pop_chk(acq_ready);
      pop_chk(mem_acq_source);

      @(negedge clock);
      push("t4_f1_src", 1);
      push("t4_f1_ardy", 4'b0010);
      push("t4_f1_bits", 64'hA000_0000_0000_0001);
      #1;
      pop_chk(mem_acq_source);
      pop_chk(acq_ready);
      pop_chk(mem_acq_bits);

      @(negedge clock);
      push("t4_f2_src", 2);
      push("t4_f2_ardy", 4'b0100);
      push("t4_f2_busy", 1);
      #1;
      pop_chk(mem_acq_source);
      pop_chk(acq_ready);
      pop_chk(busy_count);

      @(negedge clock);
      push("t4_f3_src", 3);
      push("t4_f3_ardy", 4'b1000);
      push("t4_f3_busy", 2);
      #1;
      pop_chk(mem_acq_source);
      pop_chk(acq_ready);
      pop_chk(busy_count);

      @(negedge clock);
      push("t4_all_v", 0);
      push("t4_all_busy", 3);
      #1;
      pop_chk(mem_acq_valid);
      pop_chk(busy_count);

      // four-beat grant to source 2
      @(negedge clock);
      gnt_ready = 4'b0100;
      mem_gnt_valid = 1'b1;
      mem_gnt_source = 2'd2;
      push("t5_busy4", 4);
      #1;
      pop_chk(busy_count);
      for (int b = 0; b < 4; b++) begin
         if (b > 0) @(negedge clock);
         mem_gnt_last = (b == 3);
         push("t5_gv", 4'b0100);
         push("t5_mgr", 1);
         push("t5_acqv", 0);
         #1;
         pop_chk(gnt_valid);
         pop_chk(mem_gnt_ready);
         pop_chk(mem_acq_valid);
      end

      // MSHR2 eligible again; hold it locked
      @(negedge clock);
      mem_gnt_valid = 1'b0;
      mem_gnt_last = 1'b0;
      mem_acq_ready = 1'b0;
      push("t5_re_v", 1);
      push("t5_re_src", 2);
      push("t5_re_err", 0);
      #1;
      pop_chk(mem_acq_valid);
      pop_chk(mem_acq_source);
      pop_chk(err_unexp_gnt);

      // legitimate single-beat grant to source 1
      @(negedge clock);
      gnt_ready = 4'b0010;
      mem_gnt_valid = 1'b1;
      mem_gnt_source = 2'd1;
      mem_gnt_last = 1'b1;
      push("t6_ok_gv", 4'b0010);
      push("t6_ok_src", 2);
      #1;
      pop_chk(gnt_valid);
      pop_chk(mem_acq_source);

      // unexpected grant to source 1; lock still on 2
      @(negedge clock);
      push("t6_lock_src", 2);
      push("t6_pre_err", 0);
      push("t6_bad_gv", 4'b0010);
      push("t6_bad_mgr", 1);
      #1;
      pop_chk(mem_acq_source);
      pop_chk(err_unexp_gnt);
      pop_chk(gnt_valid);
      pop_chk(mem_gnt_ready);

      @(negedge clock);
      mem_gnt_valid = 1'b0;
      push("t6_err", 1);
      push("t6_err_src", 2);
      #1;
      pop_chk(err_unexp_gnt);
      pop_chk(mem_acq_source);

      @(negedge clock);
      push("t6_sticky", 1);
      #1;
      pop_chk(err_unexp_gnt);

      // asynchronous reset mid-lock
      reset = 1'b1;
      push("t6_rst_src", 0);
      push("t6_rst_v", 1);
      push("t6_rst_err", 0);
      push("t6_rst_busy", 0);
      push("t6_rst_ardy", 0);
      #1;
      pop_chk(mem_acq_source);
      pop_chk(mem_acq_valid);
      pop_chk(err_unexp_gnt);
      pop_chk(busy_count);
      pop_chk(acq_ready);
      acq_valid = '0;
      push("t6_rst_idle", 0);
      #1;
      pop_chk(mem_acq_valid);

      @(negedge clock);
      reset = 1'b0;
      push("t6_post_err", 0);
      push("t6_post_busy", 0);
      #1;
      pop_chk(err_unexp_gnt);
      pop_chk(busy_count);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
